// File: rtl/eexec_unit.sv
// Multi-cycle execute/writeback stage for an 8x8 register file: IDLE -> READ -> EXEC -> WB.
// Optional macro MUL_EN enables the 8-cycle shift-add multiply for opcode 111; otherwise 111 is a NOP.
module eexec_unit #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          flag_z,
    output logic          flag_c,
    output logic          done
);

    localparam int unsigned PW = 2 * DW;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_result;
    logic          r_z;
    logic          r_c;

    logic          w_is_mul;
    logic          w_exec_done;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_c;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW:0]   w_shl;

    assign w_is_mul = (r_op == OP_MUL);

`ifdef MUL_EN
    logic [2:0]    r_cnt;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] w_partial;
    logic [PW-1:0] w_acc_next;

    // One multiplier bit per cycle: add the shifted multiplicand when the bit is set
    assign w_partial   = r_b[r_cnt] ? (PW'(r_a) << r_cnt) : '0;
    assign w_acc_next  = r_acc + w_partial;
    assign w_exec_done = !w_is_mul || (r_cnt == 3'd7);
`else
    assign w_exec_done = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (instr_valid) w_state_next = S_READ;
            S_READ: w_state_next = S_EXEC;
            S_EXEC: if (w_exec_done) w_state_next = S_WB;
            S_WB:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        rf_ra1      = r_rs1;
        rf_ra2      = r_rs2;
        rf_wa       = r_rd;
        rf_wd       = r_result;
        flag_z      = r_z;
        flag_c      = r_c;
        case (r_state)
            S_IDLE: instr_ready = 1'b1;
            S_WB: begin
                done = 1'b1;
`ifdef MUL_EN
                rf_we = 1'b1;
`else
                rf_we = !w_is_mul;
`endif
            end
            default: ;
        endcase
    end

    // Single-cycle ALU; carry-outs come from one extra MSB
    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_diff    = {1'b0, r_a} - {1'b0, r_b};
        w_shl     = {1'b0, r_a} << r_b[2:0];
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            OP_ADD: begin w_alu_res = w_sum[DW-1:0];  w_alu_c = w_sum[DW];  end
            OP_SUB: begin w_alu_res = w_diff[DW-1:0]; w_alu_c = w_diff[DW]; end
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            OP_SHL: begin w_alu_res = w_shl[DW-1:0];  w_alu_c = w_shl[DW];  end
            OP_MOV: w_alu_res = r_a;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
`ifdef MUL_EN
            r_cnt    <= '0;
            r_acc    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op  <= instr_op;
                        r_rd  <= instr_rd;
                        r_rs1 <= instr_rs1;
                        r_rs2 <= instr_rs2;
                    end
                end
                S_READ: begin
                    r_a <= rf_rd1;
                    r_b <= rf_rd2;
`ifdef MUL_EN
                    r_cnt <= '0;
                    r_acc <= '0;
`endif
                end
                S_EXEC: begin
                    if (!w_is_mul) begin
                        r_result <= w_alu_res;
                        r_z      <= (w_alu_res == '0);
                        r_c      <= w_alu_c;
                    end
`ifdef MUL_EN
                    else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_result <= w_acc_next[DW-1:0];
                            r_z      <= (w_acc_next[DW-1:0] == '0);
                            r_c      <= |w_acc_next[PW-1:DW];
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eexec_unit.sv
// Self-checking bench for eexec_unit: register file model, directed cases and randomized
// instructions checked against an arithmetic reference model.
module tb_eexec_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = '0;
    logic [2:0] instr_rd = '0;
    logic [2:0] instr_rs1 = '0;
    logic [2:0] instr_rs2 = '0;
    logic [2:0] rf_ra1, rf_ra2, rf_wa;
    logic [7:0] rf_rd1, rf_rd2, rf_wd;
    logic       rf_we, flag_z, flag_c, done;

    eexec_unit #(.DW(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .flag_z(flag_z), .flag_c(flag_c), .done(done)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, write on rising edge
    logic [7:0] rf_mem [8];
    logic       tb_load = 1'b0;
    logic [2:0] tb_la = '0;
    logic [7:0] tb_ld = '0;
    assign rf_rd1 = rf_mem[rf_ra1];
    assign rf_rd2 = rf_mem[rf_ra2];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_wa] <= rf_wd;
        else if (tb_load) rf_mem[tb_la] <= tb_ld;
    end

    // Reference state
    logic [7:0] ref_rf [8];
    logic       ref_z = 1'b0;
    logic       ref_c = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference semantics from plain integer arithmetic
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic c, output logic we, output int lat);
        int unsigned ia, ib, full, sh;
        ia = 32'(a); ib = 32'(b); sh = ib % 8;
        res = '0; c = 1'b0; we = 1'b1; lat = 3;
        case (op)
            3'd0: begin full = ia + ib; res = 8'(full); c = (full > 255); end
            3'd1: begin full = (ia + 256 - ib) % 256; res = 8'(full); c = (ia < ib); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                full = (ia * (32'd1 << sh)) % 256; res = 8'(full);
                c = (sh == 0) ? 1'b0 : 1'((ia >> (8 - sh)) & 1);
            end
            3'd6: res = a;
            default: begin
`ifdef MUL_EN
                full = ia * ib; res = 8'(full % 256); c = (full > 255); lat = 10;
`else
                we = 1'b0;
`endif
            end
        endcase
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        tb_load = 1'b1; tb_la = addr; tb_ld = data;
        @(negedge clk);
        tb_load = 1'b0;
        ref_rf[addr] = data;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
    endtask

    // Issue one instruction from IDLE and check its retirement
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2);
        logic [7:0] e_res;
        logic       e_c, e_we, busy_ok;
        int         e_lat, n;
        model(op, ref_rf[rs1], ref_rf[rs2], e_res, e_c, e_we, e_lat);
        check_eq("ready_before", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = 3'($urandom); instr_rd = 3'($urandom);
        instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
        n = 0; busy_ok = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (instr_ready || rf_we) busy_ok = 1'b0;
        end
        check_eq("busy_quiet", 32'(busy_ok), 32'd1);
        check_eq("latency", n, e_lat);
        check_eq("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            check_eq("rf_wa", 32'(rf_wa), 32'(rd));
            check_eq("rf_wd", 32'(rf_wd), 32'(e_res));
            ref_rf[rd] = e_res;
            ref_z = (e_res == 8'd0);
            ref_c = e_c;
        end
        check_eq("flag_z", 32'(flag_z), 32'(ref_z));
        check_eq("flag_c", 32'(flag_c), 32'(ref_c));
        @(negedge clk);
        check_eq("pulse_end", 32'({done, rf_we}), 32'd0);
        check_eq("ready_after", 32'(instr_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check_eq({tag, "_we_done"}, 32'({rf_we, done}), 32'd0);
        check_eq({tag, "_flags"}, 32'({flag_z, flag_c}), 32'd0);
        check_eq({tag, "_wd"}, 32'(rf_wd), 32'd0);
    endtask

    initial begin
        logic [7:0] e_res;
        logic       e_c, e_we, quiet;
        int         e_lat, n, k_rst, extra;

        for (int i = 0; i < 8; i++) begin rf_mem[i] = '0; ref_rf[i] = '0; end
        #1;
        check_reset_state("reset_init");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) load(3'(i), 8'(i * 17 + 3));

        // ADD with carry
        load(3'd1, 8'hF0); load(3'd2, 8'h20);
        run_instr(3'd0, 3'd3, 3'd1, 3'd2);
        // SUB equal and SUB borrow
        load(3'd4, 8'h55); load(3'd5, 8'h55);
        run_instr(3'd1, 3'd6, 3'd4, 3'd5);
        load(3'd1, 8'h10); load(3'd2, 8'h20);
        run_instr(3'd1, 3'd5, 3'd1, 3'd2);
        // MUL (or NOP without the multiplier)
        load(3'd1, 8'h12); load(3'd2, 8'h10);
        run_instr(3'd7, 3'd4, 3'd1, 3'd2);
        // SHL boundaries: shift 0 and shift 7
        load(3'd1, 8'hC3); load(3'd2, 8'h08);
        run_instr(3'd5, 3'd6, 3'd1, 3'd2);
        load(3'd2, 8'h07);
        run_instr(3'd5, 3'd6, 3'd1, 3'd2);

        // Back-to-back with valid held high and a RAW dependency
        load(3'd1, 8'h3C); load(3'd2, 8'h47);
        model(3'd0, ref_rf[1], ref_rf[2], e_res, e_c, e_we, e_lat);
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(posedge clk);
        #1;
        instr_op = 3'd6; instr_rd = 3'd7; instr_rs1 = 3'd3; instr_rs2 = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check_eq("b2b_add_done", 32'({done, rf_we}), 32'd3);
                check_eq("b2b_add_wd", 32'(rf_wd), 32'(e_res));
            end
            if (k == 4) check_eq("b2b_ready_e4", 32'(instr_ready), 32'd1);
        end
        ref_rf[3] = e_res;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wait_done(n);
        check_eq("b2b_mov_latency", n, 3);
        check_eq("b2b_mov_wa", 32'(rf_wa), 32'd7);
        check_eq("b2b_mov_wd", 32'(rf_wd), 32'(e_res));
        ref_rf[7] = e_res; ref_z = (e_res == 8'd0); ref_c = 1'b0;
        check_eq("b2b_mov_flags", 32'({flag_z, flag_c}), 32'({ref_z, ref_c}));
        extra = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (done) extra++; end
        check_eq("b2b_no_dup", extra, 0);

        // Reset in the middle of a MUL
        load(3'd1, 8'h12); load(3'd2, 8'h10);
        instr_valid = 1'b1; instr_op = 3'd7; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
`ifdef MUL_EN
        k_rst = 7;
`else
        k_rst = 2;
`endif
        quiet = 1'b1;
        for (int k = 1; k <= k_rst; k++) begin
            @(negedge clk);
            if (done || rf_we) quiet = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_reset_state("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        ref_z = 1'b0; ref_c = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || rf_we) quiet = 1'b0;
        end
        check_eq("reset_no_retire", 32'(quiet), 32'd1);
        check_eq("reset_rf_intact", 32'(rf_mem[4]), 32'(ref_rf[4]));
        load(3'd5, 8'h81); load(3'd6, 8'h7F);
        run_instr(3'd0, 3'd0, 3'd5, 3'd6);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) load(3'($urandom), 8'($urandom));
            run_instr(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 8; i++) check_eq("rf_final", 32'(rf_mem[i]), 32'(ref_rf[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
